debounce_sync: RTL
==================

Name: debounce_sync

Overview:
Input-conditioning stage that sits directly upstream of the d_ff data input and feeds it a clean signal. It takes a raw, asynchronous, bouncy switch/button level and passes it through a two-flop synchronizer. A debounce state machine then requires the new level to stay stable for DEBOUNCE_CYCLES clocks. Outputs are a clean level, single-cycle rise/fall pulses and a wrapping press counter, all registered and usable as d for downstream flip-flops.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required before a level change is accepted; legal range 1..65535.
CNT_W, 4, width of press_count; wraps modulo 2^CNT_W.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
d_raw  input  1  raw asynchronous switch/button level.
d_clean  output  1  debounced, synchronized level (registered).
rise  output  1  one-cycle pulse when d_clean goes 0->1 (registered).
fall  output  1  one-cycle pulse when d_clean goes 1->0 (registered).
press_count  output  CNT_W  number of accepted rising edges, modulo 2^CNT_W (registered).

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. No asynchronous reset path.
- Reset values: sync1=0, sync2=0, state=STABLE_LOW, debounce counter=0, d_clean=0, rise=0, fall=0, press_count=0.
- Synchronizer: sync1<=d_raw; sync2<=sync1. The FSM uses only sync2.
- Debounce counter width: $clog2(DEBOUNCE_CYCLES+1).
- FSM states: STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW.
- STABLE_LOW: if sync2=1 -> CHECK_HIGH, counter<=0; else stay.
- CHECK_HIGH:
  - if sync2=0 -> STABLE_LOW (bounce rejected, no output change).
  - else if counter==DEBOUNCE_CYCLES-1 -> STABLE_HIGH; d_clean<=1, rise<=1, press_count<=press_count+1.
  - else counter<=counter+1.
- STABLE_HIGH / CHECK_LOW: mirror of the above with polarity inverted. Acceptance sets d_clean<=0 and fall<=1. press_count is unchanged on fall.
- rise and fall default to 0 every cycle; each is high for exactly one cycle per accepted edge. They are never high together.
- Latency: if d_raw changes and is first captured by sync1 at edge k, and stays stable, d_clean and the pulse update at edge k+1+DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges after capture.
- Bounce: any glitch shorter than DEBOUNCE_CYCLES synchronized samples produces no output activity. Re-entering CHECK_* always restarts the counter at 0.
- press_count wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-operation: rst has priority over all transitions. The FSM returns to STABLE_LOW, outputs clear, and an in-progress acceptance is discarded with no pulse. If d_raw is held high through reset, a rise is produced DEBOUNCE_CYCLES+2 edges after rst deasserts.
- DEBOUNCE_CYCLES=1: a change is accepted on the first CHECK_* cycle.

Decomposition:
- Shared package debounce_pkg holds:
  - state enum {STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW}, 2-bit encoding 00/01/10/11;
  - default constants DEBOUNCE_CYCLES_DEF=4 and CNT_W_DEF=4.
- One sub-module, sync_2ff (ports clk, rst, d_in, d_out), is reused for any other asynchronous inputs.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, CNT_W=4, clk period 20 ns.
1. Reset: assert rst 2 cycles with d_raw=1 -> d_clean=0, rise=0, fall=0, press_count=0 while rst is high.
2. Clean press: d_raw 0->1 captured at edge k -> d_clean=1 and rise=1 at edge k+6 only; press_count=1.
3. Bounce: d_raw high for 2 cycles, low for 1, then high steady -> no pulse during the glitch; a single rise 6 edges after the final capture; press_count increments by 1 only.
4. Release: from d_clean=1, d_raw 1->0 captured at edge k -> d_clean=0 and fall=1 at edge k+6; press_count unchanged.
5. Wrap: 17 clean press/release pairs -> press_count sequence ends ...,15,0,1.
6. Reset mid-check: rst pulsed at the third CHECK_HIGH cycle -> no rise; d_clean=0. With d_raw held high, rise occurs 6 edges after rst deasserts.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce_sync input-conditioning stage.
package debounce_pkg;

   typedef enum logic [1:0] {
      STABLE_LOW  = 2'b00,
      CHECK_HIGH  = 2'b01,
      STABLE_HIGH = 2'b10,
      CHECK_LOW   = 2'b11
   } db_state_t;

   localparam int DEBOUNCE_CYCLES_DEF = 4;
   localparam int CNT_W_DEF           = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; reusable for any async input.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d_in,
   output logic d_out
);

   logic sync1;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         d_out <= 1'b0;
      end else begin
         sync1 <= d_in;
         d_out <= sync1;
      end
   end

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes a bouncy switch level and accepts a change only after it holds
// for DEBOUNCE_CYCLES consecutive synchronized samples; emits level, edge pulses, press count.
module debounce_sync
   import debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             d_raw,
   output logic             d_clean,
   output logic             rise,
   output logic             fall,
   output logic [CNT_W-1:0] press_count
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic      sync2;
   db_state_t state;
   logic [CW-1:0] count;

   sync_2ff u_sync (
      .clk   (clk),
      .rst   (rst),
      .d_in  (d_raw),
      .d_out (sync2)
   );

   // Any sample disagreeing with the candidate level drops back to the stable
   // state, so a later re-entry always restarts the count from zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= STABLE_LOW;
         count       <= '0;
         d_clean     <= 1'b0;
         rise        <= 1'b0;
         fall        <= 1'b0;
         press_count <= '0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         case (state)
            STABLE_LOW: begin
               if (sync2) begin
                  state <= CHECK_HIGH;
                  count <= '0;
               end
            end
            CHECK_HIGH: begin
               if (!sync2) begin
                  state <= STABLE_LOW;
               end else if (count == LAST) begin
                  state       <= STABLE_HIGH;
                  d_clean     <= 1'b1;
                  rise        <= 1'b1;
                  press_count <= press_count + CNT_W'(1);
               end else begin
                  count <= count + CW'(1);
               end
            end
            STABLE_HIGH: begin
               if (!sync2) begin
                  state <= CHECK_LOW;
                  count <= '0;
               end
            end
            CHECK_LOW: begin
               if (sync2) begin
                  state <= STABLE_HIGH;
               end else if (count == LAST) begin
                  state   <= STABLE_LOW;
                  d_clean <= 1'b0;
                  fall    <= 1'b1;
               end else begin
                  count <= count + CW'(1);
               end
            end
            default: state <= STABLE_LOW;
         endcase
      end
   end

endmodule
